// File: rtl/booth_r4_seq_multiplier.sv
// booth_r4_seq_multiplier
//   Sequential signed multiplier using radix-4 Booth recoding. It consumes two
//   multiplier bits per clock, so a product takes WIDTH/2 RUN cycles. The
//   2*WIDTH-bit result is split into HI/LO halves for the HI/LO registers.
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0
//   (state IDLE or DONE); the operands are captured on that edge. busy is high
//   for exactly WIDTH/2 cycles. done then pulses for one cycle while
//   product_hi/lo carry the new result. A start seen while busy=1 is ignored.
//   product_hi/lo hold their value until the next completion or a reset.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset (wins over start)
//   start         request, sampled only while busy==0
//   multiplicand  signed operand M
//   multiplier    signed operand Q
//   busy          high while in RUN
//   done          one-cycle completion pulse
//   product_hi    upper WIDTH bits of the signed product
//   product_lo    lower WIDTH bits of the signed product
//   dbg_state     current FSM state (0=IDLE, 1=RUN, 2=DONE)
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int             HALF = WIDTH / 2;
  localparam int             CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]  LAST = CW'(HALF - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH+1:0] r_a;     // accumulator, two guard bits so -2M never overflows
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;   // Q[-1], the bit shifted out of the previous digit
  logic [CW-1:0]    r_count;

  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_m2_ext;
  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_qm1_next;

  assign w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
  assign w_m2_ext = {r_m[WIDTH-1], r_m, 1'b0};

  // Booth digit selection from {Q[1], Q[0], Q[-1]}
  always_comb begin
    w_addend = '0;
    unique case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = w_m_ext;
      3'b011:         w_addend = w_m2_ext;
      3'b100:         w_addend = ~w_m2_ext + 1'b1;
      3'b101, 3'b110: w_addend = ~w_m_ext + 1'b1;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum = r_a + w_addend;

  // Arithmetic shift of {A, Q, Q[-1]} right by two
  assign w_a_next   = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
  assign w_q_next   = {w_sum[1:0], r_q[WIDTH-1:2]};
  assign w_qm1_next = r_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_m        <= '0;
      r_a        <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_count    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_qm1   <= w_qm1_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            // After the last digit the low WIDTH bits of A are the high half
            product_hi <= w_a_next[WIDTH-1:0];
            product_lo <= w_q_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
module tb_booth_r4_seq_multiplier;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  booth_r4_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // steps until done is seen, bounded; edge count is checked by the caller
  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  // scoreboard: expected product pushed at start, popped at done
  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
    int n;
    logic [2*W-1:0] e;
    exp_q.push_back(exp);
    start_op(a, b);
    step();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'(16));
    chk({tag, "_done"}, 64'(done), 64'(1));
    e = exp_q.pop_front();
    chk({tag, "_prod"}, {product_hi, product_lo}, e);
    step();
    chk({tag, "_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  function automatic logic [W-1:0] pick(input int sel);
    logic [W-1:0] v;
    case (sel)
      0:       v = '0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    int n;
    int m;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic signed [2*W-1:0] rp;

    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_prod", {product_hi, product_lo}, 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));

    // reset wins over start
    start_op(32'd3, 32'd3);
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_over_start", 64'(busy), 64'(0));
    step();

    // directed vectors
    run_vec("7xm3",    32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_vec("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_vec("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    run_vec("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_vec("minxmax", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    run_vec("zero",    32'd0,         32'h1234_5678, 64'h0);
    run_vec("m5x6",    32'hFFFF_FFFB, 32'd6,         64'hFFFF_FFFF_FFFF_FFE2);
    run_vec("12345",   32'd12345,     32'd678,       64'h0000_0000_007F_B6F6);

    // start with new operands mid-run is ignored
    start_op(32'd5, 32'd6);
    step();
    start = 1'b0;
    step();
    step();
    start_op(32'd9, 32'd9);
    step();
    start = 1'b0;
    wait_done(m);
    chk("midrun_lat", 64'(3 + m), 64'(16));
    chk("midrun_prod", {product_hi, product_lo}, 64'd30);
    step();

    // back-to-back: start held high through the done cycle
    start_op(32'd5, 32'd6);
    step();
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    wait_done(n);
    chk("b2b_lat1", 64'(n), 64'(16));
    chk("b2b_prod1", {product_hi, product_lo}, 64'd30);
    step();
    start = 1'b0;
    chk("b2b_reaccept", 64'({busy, done}), 64'(2'b10));
    chk("b2b_hold", {product_hi, product_lo}, 64'd30);
    wait_done(m);
    chk("b2b_lat2", 64'(1 + m), 64'(17));
    chk("b2b_prod2", {product_hi, product_lo}, 64'd1);
    step();

    // reset in the middle of a run
    start_op(32'd12345, 32'd678);
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_flags", 64'({busy, done}), 64'(0));
    chk("midrst_prod", {product_hi, product_lo}, 64'(0));
    chk("midrst_state", 64'(dbg_state), 64'(0));
    seen = 0;
    repeat (20) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("midrst_quiet", 64'(seen), 64'(0));
    run_vec("after_rst", 32'd12345, 32'd678, 64'h0000_0000_007F_B6F6);

    // random operands including corner values, against a signed reference
    for (int i = 0; i < 300; i++) begin
      ra = pick($urandom_range(0, 8));
      rb = pick($urandom_range(0, 8));
      rp = $signed(ra) * $signed(rb);
      run_vec("rand", ra, rb, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
